// File: rtl/bus_master_if_pkg.sv
// Shared bus definitions for the 4-channel arbitrated bus.
// Holds the master interface state encoding, read/write and
// active-low enable levels, and the word address/data bus widths.
package bus_master_if_pkg;

   localparam int WORD_ADDR_W   = 30;
   localparam int WORD_DATA_W   = 32;
   localparam int BUS_MASTER_CH = 4;

   typedef logic [WORD_ADDR_W-1:0] word_addr_bus_t;
   typedef logic [WORD_DATA_W-1:0] word_data_bus_t;

   localparam logic READ     = 1'b1;
   localparam logic WRITE    = 1'b0;
   localparam logic ENABLE_  = 1'b0;
   localparam logic DISABLE_ = 1'b1;

   typedef enum logic [1:0] {
      BUS_IF_STATE_IDLE   = 2'd0,
      BUS_IF_STATE_REQ    = 2'd1,
      BUS_IF_STATE_ACCESS = 2'd2,
      BUS_IF_STATE_WAIT   = 2'd3
   } bus_if_state_e;

endpackage

// File: rtl/bus_master_if.sv
// Master side of the arbitrated bus. Turns a one-cycle core access
// strobe into request / grant / address strobe / ready, stalls the
// pipeline through busy and returns registered read data.
// Optional build macro BUS_MASTER_TIMEOUT_EN adds an ACCESS timeout
// that aborts the transfer with a bus_err pulse and all-ones read data.
module bus_master_if
   import bus_master_if_pkg::*;
#(
   parameter int ADDR_W      = WORD_ADDR_W,
   parameter int DATA_W      = WORD_DATA_W,
   parameter int TIMEOUT_CYC = 255
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic              flush,
   input  logic              as_,
   input  logic              rw,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic [DATA_W-1:0] rd_data,
   output logic              busy,
   output logic              bus_err,
   output logic              bus_req_,
   input  logic              bus_grnt_,
   output logic [ADDR_W-1:0] bus_addr,
   output logic              bus_as_,
   output logic              bus_rw,
   output logic [DATA_W-1:0] bus_wr_data,
   input  logic [DATA_W-1:0] bus_rd_data,
   input  logic              bus_rdy_
);

   bus_if_state_e state;

`ifdef BUS_MASTER_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT_CYC < 1) ? 1 : $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);
   logic [CNT_W-1:0] to_cnt;
`else
   assign bus_err = 1'b0;
`endif

   // Busy goes high in the strobe cycle itself so the core stalls at once
   always_comb begin
      busy = 1'b0;
      case (state)
         BUS_IF_STATE_IDLE:   busy = ~as_ & ~flush;
         BUS_IF_STATE_REQ:    busy = 1'b1;
         BUS_IF_STATE_ACCESS: busy = 1'b1;
         default:             busy = 1'b0;
      endcase
   end

   // Transfer sequencer: all bus-facing outputs are registered here
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= BUS_IF_STATE_IDLE;
         bus_req_    <= DISABLE_;
         bus_as_     <= DISABLE_;
         bus_rw      <= READ;
         bus_addr    <= '0;
         bus_wr_data <= '0;
         rd_data     <= '0;
`ifdef BUS_MASTER_TIMEOUT_EN
         to_cnt      <= '0;
         bus_err     <= 1'b0;
`endif
      end else begin
`ifdef BUS_MASTER_TIMEOUT_EN
         bus_err <= 1'b0;
`endif
         case (state)
            BUS_IF_STATE_IDLE: begin
               if (as_ == ENABLE_ && !flush) begin
                  bus_addr    <= addr;
                  bus_rw      <= rw;
                  bus_wr_data <= wr_data;
                  bus_req_    <= ENABLE_;
                  state       <= BUS_IF_STATE_REQ;
               end
            end
            BUS_IF_STATE_REQ: begin
               if (flush) begin
                  bus_req_ <= DISABLE_;
                  state    <= BUS_IF_STATE_IDLE;
               end else if (bus_grnt_ == ENABLE_) begin
                  bus_as_ <= ENABLE_;
                  state   <= BUS_IF_STATE_ACCESS;
`ifdef BUS_MASTER_TIMEOUT_EN
                  to_cnt  <= '0;
`endif
               end
            end
            BUS_IF_STATE_ACCESS: begin
               bus_as_ <= DISABLE_;
               if (bus_rdy_ == ENABLE_) begin
                  bus_req_ <= DISABLE_;
                  if (bus_rw == READ) begin
                     rd_data <= bus_rd_data;
                  end
                  state <= BUS_IF_STATE_WAIT;
               end
`ifdef BUS_MASTER_TIMEOUT_EN
               else if (to_cnt == TO_LAST) begin
                  bus_req_ <= DISABLE_;
                  bus_err  <= 1'b1;
                  rd_data  <= '1;
                  state    <= BUS_IF_STATE_WAIT;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
`endif
            end
            BUS_IF_STATE_WAIT: begin
               if (!stall) begin
                  state <= BUS_IF_STATE_IDLE;
               end
            end
            default: state <= BUS_IF_STATE_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bus_master_if.sv
// Scoreboard bench for bus_master_if. The driver plays both the core
// and the bus side (arbiter grant, slave ready) from a per-transfer
// plan and pushes the expected bus phase and completion into queues;
// a monitor pops them when bus_as_ pulses or busy falls.
module tb_bus_master_if;

`ifdef BUS_MASTER_TIMEOUT_EN
   localparam int TO_CYC = 8;
   localparam bit TO_EN  = 1'b1;
`else
   localparam int TO_CYC = 255;
   localparam bit TO_EN  = 1'b0;
`endif

   logic        clk;
   logic        reset;
   logic        stall;
   logic        flush;
   logic        as_;
   logic        rw;
   logic [29:0] addr;
   logic [31:0] wr_data;
   logic [31:0] rd_data;
   logic        busy;
   logic        bus_err;
   logic        bus_req_;
   logic        bus_grnt_;
   logic [29:0] bus_addr;
   logic        bus_as_;
   logic        bus_rw;
   logic [31:0] bus_wr_data;
   logic [31:0] bus_rd_data;
   logic        bus_rdy_;

   typedef struct {
      logic [29:0] addr;
      logic        rw;
      logic [31:0] wd;
   } as_exp_t;

   typedef struct {
      logic [31:0] rd;
      logic        err;
      int          busy_cyc;
   } done_exp_t;

   as_exp_t   as_q[$];
   done_exp_t done_q[$];

   int          checks = 0;
   int          errors = 0;
   logic [31:0] model_rd;

   bus_master_if #(
      .ADDR_W(30),
      .DATA_W(32),
      .TIMEOUT_CYC(TO_CYC)
   ) dut (
      .clk(clk),
      .reset(reset),
      .stall(stall),
      .flush(flush),
      .as_(as_),
      .rw(rw),
      .addr(addr),
      .wr_data(wr_data),
      .rd_data(rd_data),
      .busy(busy),
      .bus_err(bus_err),
      .bus_req_(bus_req_),
      .bus_grnt_(bus_grnt_),
      .bus_addr(bus_addr),
      .bus_as_(bus_as_),
      .bus_rw(bus_rw),
      .bus_wr_data(bus_wr_data),
      .bus_rd_data(bus_rd_data),
      .bus_rdy_(bus_rdy_)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One core transfer. g: REQ cycle index at which grant arrives,
   // r: ACCESS cycle index at which ready arrives, f: REQ cycle index
   // of a flush (-1 for none), st: WAIT cycles held by stall.
   task automatic applyStimulus(input logic t_rw, input logic [29:0] t_addr,
                                input logic [31:0] t_wd, input int g, input int r,
                                input int f, input int st, input logic [31:0] t_rd);
      as_exp_t   a;
      done_exp_t d;
      bit        flushed;
      bit        timed_out;
      int        acc_len;
      flushed   = (f >= 0) && (f <= g);
      timed_out = TO_EN && (r >= TO_CYC);
      acc_len   = timed_out ? TO_CYC : r + 1;
      if (flushed) begin
         d.rd       = model_rd;
         d.err      = 1'b0;
         d.busy_cyc = f + 2;
      end else begin
         a.addr = t_addr;
         a.rw   = t_rw;
         a.wd   = t_wd;
         as_q.push_back(a);
         d.rd       = timed_out ? 32'hFFFF_FFFF : (t_rw ? t_rd : model_rd);
         d.err      = timed_out;
         d.busy_cyc = 1 + (g + 1) + acc_len;
      end
      model_rd = d.rd;
      done_q.push_back(d);

      as_     = 1'b0;
      rw      = t_rw;
      addr    = t_addr;
      wr_data = t_wd;
      flush   = 1'b0;
      @(posedge clk); #1;
      as_     = 1'b1;
      rw      = 1'($urandom);
      addr    = 30'($urandom);
      wr_data = $urandom;
      if (flushed) begin
         for (int i = 0; i <= f; i++) begin
            bus_grnt_ = (i >= g) ? 1'b0 : 1'b1;
            flush     = (i == f);
            @(posedge clk); #1;
         end
         flush     = 1'b0;
         bus_grnt_ = 1'b1;
         @(posedge clk); #1;
      end else begin
         for (int i = 0; i <= g; i++) begin
            bus_grnt_ = (i >= g) ? 1'b0 : 1'b1;
            @(posedge clk); #1;
         end
         for (int j = 0; j < acc_len; j++) begin
            bus_rdy_    = (j == r) ? 1'b0 : 1'b1;
            bus_rd_data = (j == r) ? t_rd : $urandom;
            flush       = 1'($urandom);
            @(posedge clk); #1;
         end
         bus_rdy_  = 1'b1;
         bus_grnt_ = 1'b1;
         flush     = 1'b0;
         for (int k = 0; k < st; k++) begin
            stall = 1'b1;
            as_   = 1'b0;
            @(posedge clk); #1;
         end
         stall = 1'b0;
         as_   = 1'b1;
         @(posedge clk); #1;
      end
   endtask

   // Monitor: bus phase on every bus_as_ pulse, completion on busy falling
   int        run_len = 0;
   bit        prev_as_low = 1'b0;
   logic [31:0] last_rd = '0;
   as_exp_t   mon_a;
   done_exp_t mon_d;

   always @(negedge clk) begin
      if (!reset) begin
         run_len     = 0;
         prev_as_low = 1'b0;
         last_rd     = '0;
      end else begin
         if (bus_as_ == 1'b0) begin
            checkOutput("bus_as_pulse_width", 64'(prev_as_low), 64'd0);
            if (!prev_as_low) begin
               if (as_q.size() == 0) begin
                  checkOutput("bus_as_unplanned", 64'(bus_as_), 64'd1);
               end else begin
                  mon_a = as_q.pop_front();
                  checkOutput("bus_addr", 64'(bus_addr), 64'(mon_a.addr));
                  checkOutput("bus_rw", 64'(bus_rw), 64'(mon_a.rw));
                  if (mon_a.rw == 1'b0)
                     checkOutput("bus_wr_data", 64'(bus_wr_data), 64'(mon_a.wd));
                  checkOutput("bus_req_during_as", 64'(bus_req_), 64'd0);
               end
            end
         end
         prev_as_low = (bus_as_ == 1'b0);

         if (busy) begin
            checkOutput("bus_req_while_busy", 64'(bus_req_), (run_len == 0) ? 64'd1 : 64'd0);
            run_len++;
         end else if (run_len > 0) begin
            if (done_q.size() == 0) begin
               checkOutput("busy_fall_pending", 64'(done_q.size()), 64'd1);
            end else begin
               mon_d = done_q.pop_front();
               checkOutput("busy_cycles", 64'(run_len), 64'(mon_d.busy_cyc));
               checkOutput("rd_data_done", 64'(rd_data), 64'(mon_d.rd));
               checkOutput("bus_err_done", 64'(bus_err), 64'(mon_d.err));
               checkOutput("bus_req_done", 64'(bus_req_), 64'd1);
               last_rd = mon_d.rd;
            end
            run_len = 0;
         end else begin
            checkOutput("rd_data_idle", 64'(rd_data), 64'(last_rd));
            checkOutput("bus_req_idle", 64'(bus_req_), 64'd1);
            checkOutput("bus_as_idle", 64'(bus_as_), 64'd1);
            checkOutput("bus_err_idle", 64'(bus_err), 64'd0);
         end
      end
   end

   initial begin
      reset       = 1'b0;
      stall       = 1'b0;
      flush       = 1'b0;
      as_         = 1'b1;
      rw          = 1'b1;
      addr        = '0;
      wr_data     = '0;
      bus_grnt_   = 1'b1;
      bus_rdy_    = 1'b1;
      bus_rd_data = '0;
      model_rd    = '0;
      repeat (3) @(posedge clk);
      #3 reset = 1'b1;
      @(posedge clk); #1;

      checkOutput("rst_bus_req_", 64'(bus_req_), 64'd1);
      checkOutput("rst_bus_as_", 64'(bus_as_), 64'd1);
      checkOutput("rst_bus_rw", 64'(bus_rw), 64'd1);
      checkOutput("rst_bus_addr", 64'(bus_addr), 64'd0);
      checkOutput("rst_bus_wr_data", 64'(bus_wr_data), 64'd0);
      checkOutput("rst_rd_data", 64'(rd_data), 64'd0);
      checkOutput("rst_busy", 64'(busy), 64'd0);
      checkOutput("rst_bus_err", 64'(bus_err), 64'd0);

      // read with immediate grant and ready: busy for 3 cycles
      applyStimulus(1'b1, 30'h10, 32'h0, 0, 0, -1, 0, 32'hDEAD_BEEF);
      // write with grant held off for 4 REQ cycles
      applyStimulus(1'b0, 30'h2A5, 32'h1234_5678, 4, 1, -1, 0, 32'h5555_AAAA);
      // flush two cycles into REQ with no grant
      applyStimulus(1'b1, 30'h77, 32'h0, 99, 0, 2, 0, 32'h0BAD_0BAD);
      // flush and grant in the same cycle: flush wins
      applyStimulus(1'b1, 30'h78, 32'h0, 1, 0, 1, 0, 32'h0BAD_0BAD);
      // read then stall in WAIT for 3 cycles with the core re-strobing
      applyStimulus(1'b1, 30'h3000, 32'h0, 1, 2, -1, 3, 32'hCAFE_0001);
`ifdef BUS_MASTER_TIMEOUT_EN
      // no ready at all: abort after TO_CYC ACCESS cycles
      applyStimulus(1'b1, 30'h44, 32'h0, 0, 99, -1, 1, 32'h0);
      // ready in the same cycle as the timeout: normal completion
      applyStimulus(1'b1, 30'h45, 32'h0, 0, TO_CYC - 1, -1, 0, 32'h600D_F00D);
`endif

      for (int n = 0; n < 40; n++) begin
         int g, r, f;
         g = int'($urandom_range(0, 4));
         r = TO_EN ? int'($urandom_range(0, 10)) : int'($urandom_range(0, 5));
         f = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3)) : -1;
         applyStimulus(1'($urandom), 30'($urandom), $urandom, g, r, f,
                       int'($urandom_range(0, 3)), $urandom);
      end

      // reset asserted asynchronously while waiting for ready
      as_     = 1'b0;
      rw      = 1'b1;
      addr    = 30'h1F0;
      wr_data = 32'h0;
      as_q.push_back('{addr: 30'h1F0, rw: 1'b1, wd: 32'h0});
      @(posedge clk); #1;
      as_       = 1'b1;
      bus_grnt_ = 1'b0;
      @(posedge clk); #1;
      repeat (3) @(posedge clk);
      #2 reset = 1'b0;
      #1;
      checkOutput("mid_rst_bus_req_", 64'(bus_req_), 64'd1);
      checkOutput("mid_rst_bus_as_", 64'(bus_as_), 64'd1);
      checkOutput("mid_rst_busy", 64'(busy), 64'd0);
      checkOutput("mid_rst_rd_data", 64'(rd_data), 64'd0);
      model_rd  = '0;
      bus_grnt_ = 1'b1;
      @(posedge clk);
      #3 reset = 1'b1;
      @(posedge clk); #1;

      // a transfer after the mid-transfer reset must work normally
      applyStimulus(1'b1, 30'h99, 32'h0, 2, 1, -1, 0, 32'hA5A5_5A5A);

      repeat (5) @(posedge clk);
      #1;
      checkOutput("as_q_drained", 64'(as_q.size()), 64'd0);
      checkOutput("done_q_drained", 64'(done_q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
